// File: rtl/ldpc_frame_ctrl_if.sv
// LLR sample stream from the quantizer into the frame controller.
// The source drives llr_valid/llr; the controller drives llr_ready. A sample moves when both are high.
interface ldpc_frame_ctrl_if #(
  parameter int data_w = 5
) ();
  logic              llr_valid;
  logic [data_w-1:0] llr;
  logic              llr_ready;

  modport master (output llr_valid, output llr, input llr_ready);
  modport slave  (input llr_valid, input llr, output llr_ready);
endinterface

// File: rtl/ldpc_frame_ctrl.sv
// LDPC test-path sequencer: loads a frame of LLRs, runs the decoder until term or timeout, then counts errors.
// All outputs are registered or decoded from state. llr_ready is high only in LOAD, so the source stalls otherwise.
module ldpc_frame_ctrl #(
  parameter int data_w = 5,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int TMO    = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run,
  input  logic                    stat_clr,
  ldpc_frame_ctrl_if.slave        llr_if,
  output logic [R*D*data_w-1:0]   sig,
  output logic                    dec_rst,
  output logic                    dec_en,
  input  logic                    term,
  input  logic [R*D-1:0]          res,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_ok,
  output logic [11:0]             frame_errs,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             err_total,
  output logic [15:0]             fail_cnt
);

  localparam int DIM = R * D;
  localparam int BW  = DIM * data_w;
  localparam int SW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW  = $clog2(TMO);
  localparam int KW  = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, CLR, DECODE, COUNT, REPORT} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [KW-1:0]   k_q, k_d;
  logic [11:0]     acc_q, acc_d;
  logic            ok_q, ok_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic            frame_ok_q, frame_ok_d;
  logic [11:0]     frame_errs_q, frame_errs_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]     err_total_q, err_total_d;
  logic [15:0]     fail_cnt_q, fail_cnt_d;

  logic [D-1:0]    row;
  logic [11:0]     acc_sum;
  logic [32:0]     err_sum;

  function automatic logic [11:0] popcnt(input logic [D-1:0] v);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < D; i++) begin
      c = c + 12'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    k_d          = k_q;
    acc_d        = acc_q;
    ok_d         = ok_q;
    buf_d        = buf_q;
    frame_ok_d   = frame_ok_q;
    frame_errs_d = frame_errs_q;
    frame_cnt_d  = frame_cnt_q;
    err_total_d  = err_total_q;
    fail_cnt_d   = fail_cnt_q;
    row          = res[int'(k_q)*D +: D];
    acc_sum      = acc_q + popcnt(row);
    err_sum      = {1'b0, err_total_q} + 33'(frame_errs_q);

    case (state_q)
      IDLE: begin
        if (run) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (llr_if.llr_valid) begin
          // Shift toward the MSB so the first sample lands in the top slot.
          buf_d = {buf_q[BW-data_w-1:0], llr_if.llr};
          if (cnt_q == SW'(DIM - 1)) begin
            cnt_d   = '0;
            state_d = CLR;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end
      CLR: begin
        cyc_d   = '0;
        state_d = DECODE;
      end
      DECODE: begin
        // term at cyc 0 is left over from the previous frame's decoder state.
        if (cyc_q != '0 && term) begin
          ok_d    = 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = COUNT;
        end else if (cyc_q == CW'(TMO - 1)) begin
          ok_d    = 1'b0;
          k_d     = '0;
          acc_d   = '0;
          state_d = COUNT;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      COUNT: begin
        acc_d = acc_sum;
        if (k_q == KW'(R - 1)) begin
          frame_errs_d = acc_sum;
          frame_ok_d   = ok_q;
          state_d      = REPORT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      REPORT: begin
        frame_cnt_d = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 32'd1;
        err_total_d = err_sum[32] ? '1 : err_sum[31:0];
        if (!frame_ok_q && !(&fail_cnt_q)) begin
          fail_cnt_d = fail_cnt_q + 16'd1;
        end
        state_d = run ? LOAD : IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (stat_clr) begin
      frame_cnt_d = '0;
      err_total_d = '0;
      fail_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cyc_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      ok_q         <= 1'b0;
      buf_q        <= '0;
      frame_ok_q   <= 1'b0;
      frame_errs_q <= '0;
      frame_cnt_q  <= '0;
      err_total_q  <= '0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      ok_q         <= ok_d;
      buf_q        <= buf_d;
      frame_ok_q   <= frame_ok_d;
      frame_errs_q <= frame_errs_d;
      frame_cnt_q  <= frame_cnt_d;
      err_total_q  <= err_total_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign llr_if.llr_ready = (state_q == LOAD);
  assign dec_rst          = (state_q == CLR);
  assign dec_en           = (state_q == DECODE);
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == REPORT);
  assign sig              = buf_q;
  assign frame_ok         = frame_ok_q;
  assign frame_errs       = frame_errs_q;
  assign frame_cnt        = frame_cnt_q;
  assign err_total        = err_total_q;
  assign fail_cnt         = fail_cnt_q;

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Directed bench: a small instance (R=2, D=4, TMO=16) for load/decode/count/clear/reset,
// and a default-size instance for the run-drop frame period.
module tb_ldpc_frame_ctrl;
  localparam int W    = 5;
  localparam int SR   = 2;
  localparam int SD   = 4;
  localparam int STMO = 16;
  localparam int SDIM = SR * SD;
  localparam int BR   = 24;
  localparam int BD   = 96;
  localparam int BDIM = BR * BD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, run, stat_clr, term;
  logic [SDIM-1:0]   res;
  logic [SDIM*W-1:0] sig;
  logic              dec_rst, dec_en, busy, frame_done, frame_ok;
  logic [11:0]       frame_errs;
  logic [31:0]       frame_cnt, err_total;
  logic [15:0]       fail_cnt;

  logic              b_rstn, b_run, b_stat_clr, b_term;
  logic [BDIM-1:0]   b_res;
  logic [BDIM*W-1:0] b_sig;
  logic              b_dec_rst, b_dec_en, b_busy, b_done, b_frame_ok;
  logic [11:0]       b_frame_errs;
  logic [31:0]       b_frame_cnt, b_err_total;
  logic [15:0]       b_fail_cnt;

  ldpc_frame_ctrl_if #(.data_w(W)) s_if ();
  ldpc_frame_ctrl_if #(.data_w(W)) b_if ();

  ldpc_frame_ctrl #(.data_w(W), .R(SR), .D(SD), .TMO(STMO)) dut (
    .clk(clk), .rstn(rstn), .run(run), .stat_clr(stat_clr), .llr_if(s_if),
    .sig(sig), .dec_rst(dec_rst), .dec_en(dec_en), .term(term), .res(res),
    .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_errs(frame_errs), .frame_cnt(frame_cnt), .err_total(err_total),
    .fail_cnt(fail_cnt)
  );

  ldpc_frame_ctrl #(.data_w(W), .R(BR), .D(BD), .TMO(1024)) dut_big (
    .clk(clk), .rstn(b_rstn), .run(b_run), .stat_clr(b_stat_clr), .llr_if(b_if),
    .sig(b_sig), .dec_rst(b_dec_rst), .dec_en(b_dec_en), .term(b_term), .res(b_res),
    .busy(b_busy), .frame_done(b_done), .frame_ok(b_frame_ok),
    .frame_errs(b_frame_errs), .frame_cnt(b_frame_cnt), .err_total(b_err_total),
    .fail_cnt(b_fail_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds 8 samples base..base+7; returns at the negedge of the CLR cycle.
  task automatic load_small(input int base, input bit toggle);
    int n = 0;
    int c = 0;
    while (n < SDIM && c < 100) begin
      @(negedge clk);
      s_if.llr_valid = !toggle || (c % 2 == 0);
      s_if.llr       = 5'(base + n);
      if (s_if.llr_valid && s_if.llr_ready) n++;
      c++;
    end
    if (n < SDIM) chk("load_timeout", 64'(n), 64'(SDIM));
    @(negedge clk);
    s_if.llr_valid = 1'b0;
  endtask

  // Drives term high in the DECODE cycle with cyc == term_cyc; returns at the REPORT negedge.
  task automatic run_decode(input int term_cyc, output int dcyc, output int lat);
    int t_ix = -1;
    int i    = 0;
    dcyc = 0;
    lat  = -1;
    while (i < 200) begin
      @(negedge clk);
      if (i == 0) chk("dec_rst_one_cycle", dec_rst, 0);
      if (frame_done) begin
        if (t_ix >= 0) lat = i - t_ix;
        break;
      end
      if (dec_en) begin
        term = (dcyc == term_cyc);
        if (term) t_ix = i;
        dcyc++;
      end else begin
        term = 1'b0;
      end
      i++;
    end
    term = 1'b0;
    if (i >= 200) chk("decode_timeout", 0, 1);
  endtask

  initial begin
    logic [SDIM*W-1:0] exp_sig;
    int dcyc, lat;
    int bc, acc, dc, it;

    rstn = 0; run = 0; stat_clr = 0; term = 0; res = '0;
    s_if.llr_valid = 0; s_if.llr = '0;
    b_rstn = 0; b_run = 0; b_stat_clr = 0; b_term = 0; b_res = '0;
    b_if.llr_valid = 0; b_if.llr = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", s_if.llr_ready, 0);
    chk("rst_dec_rst", dec_rst, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_sig", 64'(sig), 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rstn = 1; b_rstn = 1;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    run = 1;
    @(negedge clk);
    chk("load_ready", s_if.llr_ready, 1);

    // Frame 1: toggling valid, converge at cyc 3, res = 0x05.
    load_small(1, 1'b1);
    exp_sig = '0;
    for (int i = 1; i <= SDIM; i++) exp_sig = (exp_sig << W) | (SDIM*W)'(i);
    chk("clr_dec_rst", dec_rst, 1);
    chk("clr_dec_en", dec_en, 0);
    chk("clr_ready", s_if.llr_ready, 0);
    chk("load_order_sig", 64'(sig), 64'(exp_sig));
    res = 8'h05;
    run_decode(3, dcyc, lat);
    chk("conv_dec_cycles", 64'(dcyc), 4);
    chk("conv_done_latency", 64'(lat), SR + 1);
    chk("conv_ok", frame_ok, 1);
    chk("conv_errs", frame_errs, 2);
    @(negedge clk);
    chk("b2b_ready", s_if.llr_ready, 1);
    chk("conv_frame_cnt", frame_cnt, 1);
    chk("conv_err_total", err_total, 2);
    chk("conv_fail_cnt", fail_cnt, 0);

    // Frame 2: timeout with every bit wrong.
    res = 8'hFF;
    load_small(9, 1'b0);
    run_decode(-1, dcyc, lat);
    chk("tmo_dec_cycles", 64'(dcyc), STMO);
    chk("tmo_ok", frame_ok, 0);
    chk("tmo_errs", frame_errs, 8);
    @(negedge clk);
    chk("tmo_fail_cnt", fail_cnt, 1);
    chk("tmo_frame_cnt", frame_cnt, 2);
    chk("tmo_err_total", err_total, 10);

    // Frame 3: stale term at cyc 0 only, then stat_clr in REPORT.
    res = 8'h03;
    load_small(17, 1'b0);
    run_decode(0, dcyc, lat);
    chk("stale_dec_cycles", 64'(dcyc), STMO);
    chk("stale_ok", frame_ok, 0);
    chk("stale_errs", frame_errs, 2);
    stat_clr = 1;
    @(negedge clk);
    stat_clr = 0;
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_err_total", err_total, 0);
    chk("clr_fail_cnt", fail_cnt, 0);
    chk("clr_keeps_errs", frame_errs, 2);

    // Frame 4: async reset mid-DECODE.
    load_small(3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dec_en", dec_en, 1);
    rstn = 0;
    #1;
    chk("arst_dec_en", dec_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", s_if.llr_ready, 0);
    chk("arst_sig", 64'(sig), 0);
    chk("arst_errs", frame_errs, 0);
    chk("arst_ok", frame_ok, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("post_rst_ready", s_if.llr_ready, 1);
    run = 0;

    // Default size: drop run mid-LOAD, converge at cyc 5, all-zero res.
    bc = 0; acc = 0; dc = 0; it = 0;
    b_run = 1;
    while (it < 6000) begin
      @(negedge clk);
      it++;
      if (b_busy) bc++;
      if (b_done) break;
      b_if.llr_valid = 1'b1;
      b_if.llr       = 5'(acc + 1);
      if (b_if.llr_ready) begin
        acc++;
        if (acc == 10) b_run = 0;
      end
      if (b_dec_en) begin
        b_term = (dc == 5);
        dc++;
      end else begin
        b_term = 1'b0;
      end
    end
    b_term = 0;
    b_if.llr_valid = 0;
    if (it >= 6000) chk("big_timeout", 0, 1);
    chk("big_period", 64'(bc), BDIM + 1 + 6 + BR + 1);
    chk("big_dec_cycles", 64'(dc), 6);
    chk("big_ok", b_frame_ok, 1);
    chk("big_errs", b_frame_errs, 0);
    @(negedge clk);
    chk("big_idle_busy", b_busy, 0);
    chk("big_idle_ready", b_if.llr_ready, 0);
    chk("big_frame_cnt", b_frame_cnt, 1);
    chk("big_top_slot", 64'(b_sig[BDIM*W-1 -: W]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldpc_frame_ctrl.md
# ldpc_frame_ctrl

Frame sequencer for the LDPC decoder test path. It collects quantized LLR samples from the noise/quantizer chain through a valid/ready handshake and assembles one codeword frame. It then resets and runs `ldpc_core` until `term` or a cycle timeout, counts bit errors in the hard-decision result against the all-zero codeword, and maintains running BER statistics. It sits between `quant` and `ldpc_core` and replaces ad-hoc buffer/enable glue at the top level.

## Interface
- `data_w`, 5, LLR width in bits
- `R`, 24, block columns of the base matrix
- `D`, 96, expansion factor; frame length `dim = R*D` LLRs
- `TMO`, 1024, maximum DECODE cycles per frame (≥2)
- `clk`  in  1  single clock, all logic rising-edge
- `rstn`  in  1  reset, asynchronous, active-low
- `run`  in  1  level; while high, frames are processed back to back
- `stat_clr`  in  1  synchronous pulse; zeroes `frame_cnt`, `err_total`, `fail_cnt`
- `llr_valid`  in  1  LLR sample valid
- `llr`  in  data_w  signed LLR sample
- `llr_ready`  out  1  controller accepts a sample this cycle
- `sig`  out  dim*data_w  frame buffer driven to `ldpc_core.sig`
- `dec_rst`  out  1  one-cycle synchronous reset to `ldpc_core.rst`
- `dec_en`  out  1  decoder enable
- `term`  in  1  decoder converged
- `res`  in  dim  decoder hard decisions
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse, frame statistics valid
- `frame_ok`  out  1  last frame ended by `term` (1) or timeout (0)
- `frame_errs`  out  12  bit errors in last frame
- `frame_cnt`  out  32  frames completed, saturating
- `err_total`  out  32  accumulated bit errors, saturating
- `fail_cnt`  out  16  timed-out frames, saturating

## Operation
- States: IDLE, LOAD, CLR, DECODE, COUNT, REPORT.
- **IDLE:** all strobes low. Go to LOAD when `run`=1.
- **LOAD:**
  - `llr_ready`=1. Each accept (`llr_valid & llr_ready`) performs `buf <= (buf << data_w) | llr_zero_extended`, so the first sample ends up in the top slot of `sig`.
  - A sample counter runs 0..dim-1. The accept at count dim-1 moves to CLR.
  - `run` falling mid-LOAD does not abort; the frame completes.
- **CLR:** `dec_rst`=1 and `dec_en`=0 for exactly one cycle, then DECODE.
- **DECODE:**
  - `dec_en`=1. A cycle counter `cyc` starts at 0.
  - `term` is ignored when `cyc`=0 (stale from the previous frame) and sampled from `cyc`≥1.
  - `term`=1 → COUNT with ok=1.
  - Otherwise, `cyc`=TMO-1 → COUNT with ok=0.
  - `term` and timeout in the same cycle → ok=1.
- **COUNT:**
  - `dec_en`=0, so `res` is held.
  - Runs for R cycles, index k=0..R-1. Each cycle adds popcount(`res[k*D +: D]`) to the error accumulator, which is cleared on entry.
  - After k=R-1, go to REPORT.
- **REPORT:**
  - One cycle. `frame_done`=1. `frame_ok` and `frame_errs` are registered and held until the next REPORT.
  - `frame_cnt`+=1. `err_total`+=`frame_errs`. `fail_cnt`+=!ok. All three saturate at their maximum.
  - Next state: LOAD if `run`, else IDLE.
- **`stat_clr`:** zeroes the three counters in any state. If it coincides with REPORT, the clear wins and that frame's contribution is dropped. `frame_errs` and `frame_ok` are unaffected.
- **Width:** `frame_errs` max = dim = 2304 < 4096, so it never saturates.
- **`sig`:** holds its value from end of LOAD through REPORT, and is only modified by accepts.

## Timing
- Reset (`rstn`=0, asynchronous): state IDLE, buffer and all counters 0. Every output is 0: `llr_ready`, `dec_rst`, `dec_en`, `busy`, `frame_done`, `frame_ok`, `frame_errs`, `sig`.
- All outputs are registered or decoded from the registered state only. There is no combinational path from inputs to outputs.
- Last LLR accept → `dec_rst` high next cycle → `dec_en` high the cycle after.
- Frame period with no stalls: dim + 1 + (decode cycles) + R + 1.
- `frame_done` is asserted R+1 cycles after the cycle in which `term` is sampled high.
- Back-to-back frames: `llr_ready` reasserts the cycle after REPORT, with no idle bubble.

## Test plan
- **Reset:** pulse `rstn` low mid-DECODE (R=2, D=4, TMO=16) → all outputs 0 immediately. After release with `run`=1, `llr_ready`=1 on the next edge.
- **Load order:** feed 8 samples 1..8 with `llr_valid` toggling every other cycle → exactly 8 accepts. `sig` equals 1..8 packed MSB-first. `dec_rst` pulses for one cycle after the 8th accept.
- **Converge:** `term` rises at `cyc`=3, with `res`=0x05 → `frame_done` 3 cycles later (R+1). `frame_ok`=1, `frame_errs`=2, `frame_cnt`=1, `err_total`=2.
- **Timeout:** hold `term`=0, `res`=0xFF → DECODE lasts 16 cycles. `frame_ok`=0, `frame_errs`=8, `fail_cnt`=1. Repeat with `term` high only at `cyc`=0 → still times out.
- **Clear priority:** assert `stat_clr` in the REPORT cycle → all three counters read 0 afterwards. `frame_errs` still shows the frame's value.
- **Stop:** drop `run` during LOAD → the frame completes, then IDLE with `busy`=0. Default parameters, all-zero `res` → `frame_errs`=0 and frame period = 2304+1+N+25.
